// File: rtl/cfg_int_mul_pipe_if.sv
// Stream interface of cfg_int_mul_pipe: input beat (operands, precision, mode)
// plus result beat, each with its own valid/ready handshake.
interface cfg_int_mul_pipe_if #(
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int ACC_BITWIDTH       = 40
);
  localparam int OPW = $clog2(DATA_PATH_BITWIDTH + 1);

  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_PATH_BITWIDTH-1:0] a;
  logic [DATA_PATH_BITWIDTH-1:0] b;
  logic [OPW-1:0]                op_bits;
  logic                          mode;
  logic                          acc_clr;
  logic                          out_valid;
  logic                          out_ready;
  logic [ACC_BITWIDTH-1:0]       c;
  logic                          overflow;

  modport master (
    output in_valid, a, b, op_bits, mode, acc_clr, out_ready,
    input  in_ready, out_valid, c, overflow
  );

  modport slave (
    input  in_valid, a, b, op_bits, mode, acc_clr, out_ready,
    output in_ready, out_valid, c, overflow
  );
endinterface

// File: rtl/cfg_int_mul_pipe.sv
// Three-stage unsigned multiplier / MAC with runtime MSB-aligned operand
// truncation and a globally stalled valid/ready pipeline.
module cfg_int_mul_pipe #(
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int MIN_OP_BITWIDTH    = 4,
  parameter int ACC_BITWIDTH       = 40
) (
  input logic                clk,
  input logic                rst,
  cfg_int_mul_pipe_if.slave  bus
);
  localparam int DW  = DATA_PATH_BITWIDTH;
  localparam int AW  = ACC_BITWIDTH;
  localparam int PW  = 2 * DATA_PATH_BITWIDTH;
  localparam int OPW = $clog2(DATA_PATH_BITWIDTH + 1);

  generate
    if (ACC_BITWIDTH < 2 * DATA_PATH_BITWIDTH) begin : g_acc_width_chk
      $error("ACC_BITWIDTH must be >= 2*DATA_PATH_BITWIDTH");
    end
  endgenerate

  logic          w_stall;
  logic          w_adv;
  logic [OPW-1:0] w_eff;
  logic [OPW-1:0] w_shamt;
  logic [DW-1:0]  w_mask;

  logic          r_s1_valid;
  logic [DW-1:0] r_s1_a;
  logic [DW-1:0] r_s1_b;
  logic          r_s1_mode;
  logic          r_s1_clr;

  logic          r_s2_valid;
  logic [PW-1:0] r_s2_prod;
  logic          r_s2_mode;
  logic          r_s2_clr;

  logic          r_out_valid;
  logic [AW-1:0] r_c;
  logic [AW-1:0] r_acc;
  logic          r_ovf;

  logic [AW-1:0] w_base;
  logic [AW:0]   w_sum;
  logic [AW-1:0] w_prod_ext;

  // Global enable: a held result freezes every stage, bubbles included.
  always_comb begin
    w_stall = r_out_valid & ~bus.out_ready;
    w_adv   = ~w_stall;
  end

  assign bus.in_ready  = ~rst & ~w_stall;
  assign bus.out_valid = r_out_valid;
  assign bus.c         = r_c;
  assign bus.overflow  = r_ovf;

  // Clamp requested precision into [MIN_OP_BITWIDTH, DW] and build the keep-mask.
  always_comb begin
    if (bus.op_bits < OPW'(MIN_OP_BITWIDTH)) begin
      w_eff = OPW'(MIN_OP_BITWIDTH);
    end else if (bus.op_bits > OPW'(DW)) begin
      w_eff = OPW'(DW);
    end else begin
      w_eff = bus.op_bits;
    end
    w_shamt = OPW'(DW) - w_eff;
    w_mask  = {DW{1'b1}} << w_shamt;
  end

  // Stage 1: truncated operands and beat controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= {DW{1'b0}};
      r_s1_b     <= {DW{1'b0}};
      r_s1_mode  <= 1'b0;
      r_s1_clr   <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= bus.in_valid;
      r_s1_a     <= bus.a & w_mask;
      r_s1_b     <= bus.b & w_mask;
      r_s1_mode  <= bus.mode;
      r_s1_clr   <= bus.acc_clr;
    end
  end

  // Stage 2: full-width product.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_prod  <= {PW{1'b0}};
      r_s2_mode  <= 1'b0;
      r_s2_clr   <= 1'b0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_prod  <= PW'(r_s1_a) * PW'(r_s1_b);
      r_s2_mode  <= r_s1_mode;
      r_s2_clr   <= r_s1_clr;
    end
  end

  // Accumulate path; the extra top bit of the sum is the carry-out.
  always_comb begin
    if (r_s2_clr) begin
      w_base = {AW{1'b0}};
    end else begin
      w_base = r_acc;
    end
    w_prod_ext = AW'(r_s2_prod);
    w_sum      = {1'b0, w_base} + {1'b0, w_prod_ext};
  end

  // Stage 3: result register, accumulator and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_c         <= {AW{1'b0}};
      r_acc       <= {AW{1'b0}};
      r_ovf       <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        if (r_s2_mode) begin
          r_c   <= w_sum[AW-1:0];
          r_acc <= w_sum[AW-1:0];
          r_ovf <= r_s2_clr ? w_sum[AW] : (r_ovf | w_sum[AW]);
        end else begin
          r_c <= w_prod_ext;
        end
      end
    end
  end
endmodule

// File: tb/tb_cfg_int_mul_pipe.sv
// Directed, table-driven bench for cfg_int_mul_pipe with hand-computed results.
module tb_cfg_int_mul_pipe;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  cfg_int_mul_pipe_if #(.DATA_PATH_BITWIDTH(16), .ACC_BITWIDTH(40)) bus ();

  cfg_int_mul_pipe #(
    .DATA_PATH_BITWIDTH(16),
    .MIN_OP_BITWIDTH   (4),
    .ACC_BITWIDTH      (40)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic        clr;
    logic [39:0] exp_c;
    logic        exp_ovf;
  } vec_t;

  vec_t        vt[12];
  logic [4:0]  bop[300];
  logic [15:0] ba[300];
  logic [15:0] bb[300];
  logic        bm[300];
  logic        bc[300];
  logic [39:0] gc[300];
  logic        go[300];
  int          gcyc[300];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int i, input logic [4:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic m, input logic c);
    bop[i] = op; ba[i] = a; bb[i] = b; bm[i] = m; bc[i] = c;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic m, input logic c);
    bus.in_valid = v; bus.op_bits = op; bus.a = a; bus.b = b; bus.mode = m; bus.acc_clr = c;
  endtask

  // Streams beats 0..n-1; out_ready stays low for the first 'hold' cycles.
  task automatic stream(input int n, input int hold);
    int       sent;
    int       got;
    logic     xi;
    logic     prev_stall;
    logic [39:0] prev_c;
    sent = 0; got = 0; prev_stall = 1'b0; prev_c = 40'h0;
    for (int cyc = 0; cyc < 3000 && got < n; cyc++) begin
      bus.out_ready = (cyc >= hold);
      if (sent < n) drive(1'b1, bop[sent], ba[sent], bb[sent], bm[sent], bc[sent]);
      else drive(1'b0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0);
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        chk("stall_in_ready", 64'(bus.in_ready), 64'h0);
        if (prev_stall) chk("stall_c_hold", 64'(bus.c), 64'(prev_c));
        prev_stall = 1'b1;
        prev_c = bus.c;
      end else begin
        prev_stall = 1'b0;
      end
      xi = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        gc[got] = bus.c; go[got] = bus.overflow; gcyc[got] = cyc; got++;
      end
      tick();
      if (xi) sent++;
    end
    chk("stream_complete", 64'(got), 64'(n));
    drive(1'b0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    vt[0]  = '{5'd16, 16'h1234, 16'h0010, 1'b0, 1'b0, 40'h12340,     1'b0};
    vt[1]  = '{5'd8,  16'h12FF, 16'h0101, 1'b0, 1'b0, 40'h120000,    1'b0};
    vt[2]  = '{5'd2,  16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 40'hE1000000,  1'b0};
    vt[3]  = '{5'd0,  16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 40'hE1000000,  1'b0};
    vt[4]  = '{5'd31, 16'h8001, 16'h0003, 1'b0, 1'b0, 40'h18003,     1'b0};
    vt[5]  = '{5'd12, 16'hABCD, 16'h0FFF, 1'b0, 1'b0, 40'hAB14400,   1'b0};
    vt[6]  = '{5'd4,  16'h1FFF, 16'h2FFF, 1'b0, 1'b0, 40'h2000000,   1'b0};
    vt[7]  = '{5'd16, 16'h0003, 16'h0005, 1'b1, 1'b1, 40'd15,        1'b0};
    vt[8]  = '{5'd16, 16'h0002, 16'h0002, 1'b1, 1'b0, 40'd19,        1'b0};
    vt[9]  = '{5'd16, 16'h0001, 16'h0001, 1'b0, 1'b1, 40'd1,         1'b0};
    vt[10] = '{5'd16, 16'h0001, 16'h0001, 1'b1, 1'b0, 40'd20,        1'b0};
    vt[11] = '{5'd16, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 40'hFFFE0001,  1'b0};

    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 5'd16, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    chk("rst_in_ready_low", 64'(bus.in_ready), 64'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_c", 64'(bus.c), 64'h0);
    chk("rst_overflow", 64'(bus.overflow), 64'h0);
    chk("rst_in_ready_high", 64'(bus.in_ready), 64'h1);

    // Fixed three-cycle latency of a single full-precision multiply.
    drive(1'b1, 5'd16, 16'h1234, 16'h0010, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd16, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("lat_cycle1", 64'(bus.out_valid), 64'h0);
    tick();
    chk("lat_cycle2", 64'(bus.out_valid), 64'h0);
    tick();
    chk("lat_cycle3", 64'(bus.out_valid), 64'h1);
    chk("lat_c", 64'(bus.c), 64'h12340);
    chk("lat_overflow", 64'(bus.overflow), 64'h0);
    tick();
    chk("lat_drained", 64'(bus.out_valid), 64'h0);

    for (int i = 0; i < 12; i++) begin
      set_beat(0, vt[i].op, vt[i].a, vt[i].b, vt[i].mode, vt[i].clr);
      stream(1, 0);
      chk($sformatf("vec%0d_c", i), 64'(gc[0]), 64'(vt[i].exp_c));
      chk($sformatf("vec%0d_ovf", i), 64'(go[0]), 64'(vt[i].exp_ovf));
    end

    // Back-to-back accumulation, one result per cycle.
    for (int i = 0; i < 4; i++) set_beat(i, 5'd16, 16'h0100, 16'h0100, 1'b1, (i == 0));
    stream(4, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("acc4_c%0d", i), 64'(gc[i]), 64'(40'h10000 * (i + 1)));
      chk($sformatf("acc4_cyc%0d", i), 64'(gcyc[i] - gcyc[0]), 64'(i));
    end

    // 257 maximal products: carry-out first appears on the last one.
    for (int i = 0; i < 257; i++) set_beat(i, 5'd16, 16'hFFFF, 16'hFFFF, 1'b1, (i == 0));
    stream(257, 0);
    chk("wrap_first_c", 64'(gc[0]), 64'hFFFE0001);
    chk("wrap_256_ovf", 64'(go[255]), 64'h0);
    chk("wrap_257_c", 64'(gc[256]), 64'hFDFE0101);
    chk("wrap_257_ovf", 64'(go[256]), 64'h1);
    set_beat(0, 5'd16, 16'h0002, 16'h0003, 1'b0, 1'b0);
    stream(1, 0);
    chk("mul_keeps_ovf_c", 64'(gc[0]), 64'd6);
    chk("mul_keeps_ovf", 64'(go[0]), 64'h1);
    set_beat(0, 5'd16, 16'h0001, 16'h0001, 1'b1, 1'b1);
    stream(1, 0);
    chk("clr_after_wrap_c", 64'(gc[0]), 64'd1);
    chk("clr_after_wrap_ovf", 64'(go[0]), 64'h0);

    // Backpressure: consumer blocked for the first six cycles.
    for (int i = 0; i < 6; i++) set_beat(i, 5'd16, 16'(i + 1), 16'h0002, 1'b0, 1'b0);
    stream(6, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("bp_out%0d", i), 64'(gc[i]), 64'(2 * (i + 1)));

    // Reset with three beats in flight and a non-zero accumulator.
    set_beat(0, 5'd16, 16'h0003, 16'h0003, 1'b1, 1'b1);
    stream(1, 0);
    chk("pre_rst_acc", 64'(gc[0]), 64'd9);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd16, 16'(i + 1), 16'h0005, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 5'd16, 16'h0, 16'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("midrst_c", 64'(bus.c), 64'h0);
    chk("midrst_overflow", 64'(bus.overflow), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("midrst_flushed%0d", i), 64'(bus.out_valid), 64'h0);
    end
    set_beat(0, 5'd16, 16'h0002, 16'h0002, 1'b1, 1'b0);
    stream(1, 0);
    chk("post_rst_acc_c", 64'(gc[0]), 64'd4);
    chk("post_rst_acc_ovf", 64'(go[0]), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/cfg_int_mul_pipe.md
Name: cfg_int_mul_pipe

Overview:
Pipelined unsigned integer multiplier / multiply-accumulate with runtime-selectable operand precision. Precision is reduced by MSB-aligned truncation: the low bits of each operand are zeroed. The block carries a valid/ready stream with backpressure. It is the configurable, registered successor to the unconfigured combinational arithmetic units in the datapath, and is used for accuracy/energy precision sweeps.

Parameters:
DATA_PATH_BITWIDTH, 16, operand width of a and b.
MIN_OP_BITWIDTH, 4, smallest legal runtime precision; smaller requests clamp up to it.
ACC_BITWIDTH, 40, accumulator and result width; must be >= 2*DATA_PATH_BITWIDTH (elaboration error otherwise).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input beat valid.
in_ready  out  1  block accepts a beat this cycle.
a  in  DATA_PATH_BITWIDTH  operand A, unsigned.
b  in  DATA_PATH_BITWIDTH  operand B, unsigned.
op_bits  in  $clog2(DATA_PATH_BITWIDTH+1)  kept MSBs per operand, sampled with the beat.
mode  in  1  0 = multiply, 1 = multiply-accumulate; sampled with the beat.
acc_clr  in  1  with a mode=1 beat: the accumulation starts from 0; sampled with the beat.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
c  out  ACC_BITWIDTH  product (zero-extended) or accumulator value.
overflow  out  1  sticky accumulator carry-out flag.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at posedge): all stage valids=0, out_valid=0, c=0, accumulator=0, overflow=0. in_ready=0 while rst is high. In-flight beats are discarded with no output.
- Transfer rules:
  - An input beat transfers when in_valid && in_ready.
  - An output beat transfers when out_valid && out_ready.
  - out_valid, c and overflow hold stable until the output beat transfers.
- Precision: eff = clamp(op_bits, MIN_OP_BITWIDTH, DATA_PATH_BITWIDTH). Each operand keeps bits [DW-1 : DW-eff]; the lower DW-eff bits are forced to 0. eff=DW passes operands unchanged.
- Pipeline: 3 register stages with fixed latency of 3 cycles from input transfer to out_valid, absent stalls.
  - S1: truncated operands plus mode and acc_clr.
  - S2: full 2*DW product.
  - S3: output register and accumulator.
- Stall: stall = out_valid && !out_ready. in_ready = !rst && !stall. When stall is high all stages hold (global enable); bubbles are not squeezed. Throughput is 1 beat/cycle when out_ready=1.
- Mode 0: c = zero-extended product. Accumulator and overflow are unchanged.
- Mode 1: at the S2->S3 advance, acc_next = (acc_clr ? 0 : acc) + product, modulo 2^ACC_BITWIDTH. c = acc_next, and the accumulator register takes acc_next.
  - Carry-out sets overflow, which stays set until reset or the next acc_clr beat.
  - An acc_clr beat recomputes overflow from its own addition, which is always 0 because ACC_BITWIDTH >= 2*DW.
  - acc_clr on a mode=0 beat is ignored.
- Ordering: results emerge strictly in input order. No beat is lost or duplicated under any in_ready/out_ready pattern.
- Simultaneous events:
  - Output transfer and a new S2 beat in the same cycle: S3 loads the new beat and out_valid stays 1.
  - rst dominates every other input.

Test Plan:
1. Full-precision multiply: rst released, op_bits=16, mode=0, a=0x1234, b=0x0010, out_ready=1 -> out_valid exactly 3 cycles after transfer, c=0x12340, overflow=0.
2. Truncation:
   - op_bits=8, a=0x12FF, b=0x0101 -> c=0x120000.
   - op_bits=2 (clamps to 4), a=b=0xFFFF -> c=0xE1000000.
3. Accumulate: 4 back-to-back beats, mode=1, op_bits=16, a=b=0x0100, acc_clr=1 on the first beat only -> c=0x10000, 0x20000, 0x30000, 0x40000 on consecutive cycles.
4. Overflow and wrap: ACC_BITWIDTH=40, 257 beats mode=1, a=b=0xFFFF, acc_clr on the first -> after beat 257, overflow=1 and c=0xFDFE0101. A following acc_clr beat with a=b=1 -> c=1, overflow=0.
5. Backpressure: stream 6 mode-0 beats (a=1..6, b=2) with out_ready=0 for the first 6 cycles, then 1 -> in_ready=0 while stalled; outputs are 2, 4, 6, 8, 10, 12 in order, with no loss or duplication; c holds stable while stalled.
6. Reset mid-operation: 3 beats in flight, accumulator non-zero, rst pulsed 1 cycle -> next cycle out_valid=0, c=0, overflow=0. The next mode=1 beat with acc_clr=0, a=b=2 -> c=4.
